// File: rtl/eco32f_hazard_sb.sv
// Register scoreboard for the eco32f decode stage: per-register countdowns for fixed-latency
// load/mul results plus a single outstanding variable-latency divide.
module eco32f_hazard_sb #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          id_rf_x_addr,
    input  logic [4:0]          id_rf_y_addr,
    input  logic                id_rf_x_used,
    input  logic                id_rf_y_used,
    input  logic [4:0]          id_rf_r_addr,
    input  logic                id_rf_r_we,
    input  logic [1:0]          id_wb_class,
    input  logic                id_issue,
    input  logic                pipe_stall,
    input  logic                flush,
    input  logic                div_done,
    input  logic [4:0]          div_addr,
    output logic                id_bubble,
    output logic                div_busy,
    output logic [NUM_REGS-1:0] sb_busy
);

    localparam logic [1:0] ClsAlu  = 2'd0;
    localparam logic [1:0] ClsLoad = 2'd1;
    localparam logic [1:0] ClsMul  = 2'd2;
    localparam logic [1:0] ClsDiv  = 2'd3;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                div_busy_q, div_busy_d;
    logic                hz_x, hz_y, issue;

    always_comb begin
        hz_x = (id_rf_x_addr != 5'd0) &&
               ((cnt_q[id_rf_x_addr] != '0) || pend_q[id_rf_x_addr]);
        hz_y = (id_rf_y_addr != 5'd0) &&
               ((cnt_q[id_rf_y_addr] != '0) || pend_q[id_rf_y_addr]);
        // Last two terms: WAW against a pending divide, and a single divide in flight.
        id_bubble = (id_rf_x_used && hz_x) || (id_rf_y_used && hz_y) ||
                    (id_rf_r_we && pend_q[id_rf_r_addr]) ||
                    (id_rf_r_we && (id_wb_class == ClsDiv) && div_busy_q);
        issue = id_issue && !id_bubble && id_rf_r_we && (id_rf_r_addr != 5'd0);
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (!pipe_stall && cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : cnt_q[r];
        end
        pend_d     = pend_q;
        div_busy_d = div_busy_q;

        // Completion is applied before a same-cycle issue so the issue wins.
        if (div_done && div_busy_q) begin
            div_busy_d         = 1'b0;
            pend_d[div_addr]   = 1'b0;
        end

        if (issue) begin
            unique case (id_wb_class)
                ClsAlu:  ;
                ClsLoad: cnt_d[id_rf_r_addr] = CNT_W'(LOAD_LAT);
                ClsMul:  cnt_d[id_rf_r_addr] = CNT_W'(MUL_LAT);
                ClsDiv: begin
                    pend_d[id_rf_r_addr] = 1'b1;
                    div_busy_d           = 1'b1;
                end
            endcase
        end

        if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_d[r] = '0;
            pend_d     = '0;
            div_busy_d = 1'b0;
        end

        cnt_d[0]  = '0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            pend_q     <= '0;
            div_busy_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            pend_q     <= pend_d;
            div_busy_q <= div_busy_d;
        end
    end

    // Derived purely from state registers, so no input-to-output path.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) sb_busy[r] = (cnt_q[r] != '0) || pend_q[r];
    end

    assign div_busy = div_busy_q;

endmodule

// File: tb/tb_eco32f_hazard_sb.sv
// Bench for eco32f_hazard_sb: directed scenarios plus random traffic, checked against a
// model that tracks result readiness in terms of elapsed pipeline advances.
module tb_eco32f_hazard_sb;

    localparam int LOAD_LAT = 1;
    localparam int MUL_LAT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rf_x_addr, id_rf_y_addr, id_rf_r_addr, div_addr;
    logic        id_rf_x_used, id_rf_y_used, id_rf_r_we, id_issue;
    logic [1:0]  id_wb_class;
    logic        pipe_stall, flush, div_done;
    logic        id_bubble, div_busy;
    logic [31:0] sb_busy;

    always #5 clk = ~clk;

    eco32f_hazard_sb #(
        .NUM_REGS (32),
        .LOAD_LAT (LOAD_LAT),
        .MUL_LAT  (MUL_LAT),
        .CNT_W    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rf_x_addr (id_rf_x_addr),
        .id_rf_y_addr (id_rf_y_addr),
        .id_rf_x_used (id_rf_x_used),
        .id_rf_y_used (id_rf_y_used),
        .id_rf_r_addr (id_rf_r_addr),
        .id_rf_r_we   (id_rf_r_we),
        .id_wb_class  (id_wb_class),
        .id_issue     (id_issue),
        .pipe_stall   (pipe_stall),
        .flush        (flush),
        .div_done     (div_done),
        .div_addr     (div_addr),
        .id_bubble    (id_bubble),
        .div_busy     (div_busy),
        .sb_busy      (sb_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: a result is ready once the advance count reaches ready_at[r].
    int adv = 0;
    int ready_at [32];
    bit m_pend [32];
    bit m_div_busy = 1'b0;
    int div_tgt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hz(input logic [4:0] a);
        return (a != 5'd0) && ((ready_at[a] > adv) || m_pend[a]);
    endfunction

    function automatic bit m_bubble();
        return (id_rf_x_used && m_hz(id_rf_x_addr)) || (id_rf_y_used && m_hz(id_rf_y_addr)) ||
               (id_rf_r_we && m_pend[id_rf_r_addr]) ||
               (id_rf_r_we && id_wb_class == 2'd3 && m_div_busy);
    endfunction

    function automatic logic [31:0] m_sb();
        logic [31:0] s = '0;
        for (int r = 1; r < 32; r++) s[r] = (ready_at[r] > adv) || m_pend[r];
        return s;
    endfunction

    task automatic m_clear(input int at);
        for (int r = 0; r < 32; r++) begin
            ready_at[r] = at;
            m_pend[r]   = 1'b0;
        end
        m_div_busy = 1'b0;
    endtask

    // Compare one cycle against the model, then advance the model across the clock edge.
    task automatic step();
        bit b;
        int adv_new;
        #1;
        b = m_bubble();
        if (chk_en) begin
            check_eq("id_bubble", id_bubble, b);
            check_eq("sb_busy", sb_busy, m_sb());
            check_eq("div_busy", div_busy, m_div_busy);
        end
        @(posedge clk);
        if (rst) begin
            adv = 0;
            m_clear(0);
        end else begin
            adv_new = adv + (pipe_stall ? 0 : 1);
            if (div_done && m_div_busy) begin
                m_div_busy = 1'b0;
                m_pend[div_addr] = 1'b0;
            end
            if (id_issue && !b && id_rf_r_we && id_rf_r_addr != 5'd0) begin
                case (id_wb_class)
                    2'd1: ready_at[id_rf_r_addr] = adv_new + LOAD_LAT;
                    2'd2: ready_at[id_rf_r_addr] = adv_new + MUL_LAT;
                    2'd3: begin
                        m_pend[id_rf_r_addr] = 1'b1;
                        m_div_busy = 1'b1;
                        div_tgt = int'(id_rf_r_addr);
                    end
                    default: ;
                endcase
            end
            if (flush) m_clear(adv_new);
            adv = adv_new;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_rf_x_addr = 5'd0; id_rf_y_addr = 5'd0; id_rf_r_addr = 5'd0; div_addr = 5'd0;
        id_rf_x_used = 1'b0; id_rf_y_used = 1'b0; id_rf_r_we = 1'b0; id_issue = 1'b0;
        id_wb_class = 2'd0; pipe_stall = 1'b0; flush = 1'b0; div_done = 1'b0; rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] r, input logic [1:0] cls);
        idle();
        id_rf_r_addr = r; id_rf_r_we = 1'b1; id_wb_class = cls; id_issue = 1'b1;
        step();
    endtask

    int cnt;

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        step();
        step();
        chk_en = 1'b1;
        idle();
        #1;
        check_eq("reset_sb_busy", sb_busy, 32'h0);
        check_eq("reset_div_busy", div_busy, 32'h0);
        check_eq("reset_bubble", id_bubble, 32'h0);
        step();

        // Load r5, then read it: exactly one bubble cycle.
        issue(5'd5, 2'd1);
        idle(); id_rf_x_addr = 5'd5; id_rf_x_used = 1'b1;
        #1 check_eq("load_bubble", id_bubble, 32'h1);
        check_eq("load_sb5", sb_busy, 32'h20);
        step();
        #1 check_eq("load_clear", id_bubble, 32'h0);
        step();

        // Mul r7 without stall: two bubble cycles.
        issue(5'd7, 2'd2);
        idle(); id_rf_y_addr = 5'd7; id_rf_y_used = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1 cnt += int'(id_bubble);
            step();
        end
        check_eq("mul_bubble_cycles", cnt, 2);

        // Mul r7 with three stalled cycles: five bubble cycles.
        issue(5'd7, 2'd2);
        idle(); id_rf_y_addr = 5'd7; id_rf_y_used = 1'b1; pipe_stall = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) pipe_stall = 1'b0;
            #1 cnt += int'(id_bubble);
            step();
        end
        check_eq("mul_stall_bubble_cycles", cnt, 5);

        // Divide r9 held for 10 cycles, then completion.
        issue(5'd9, 2'd3);
        idle(); id_rf_x_addr = 5'd9; id_rf_x_used = 1'b1;
        for (int i = 0; i < 10; i++) step();
        #1 check_eq("div_hold", id_bubble, 32'h1);
        div_done = 1'b1; div_addr = 5'd9;
        step();
        div_done = 1'b0;
        #1 check_eq("div_release", id_bubble, 32'h0);
        check_eq("div_busy_clear", div_busy, 32'h0);
        step();

        // Divide r3 outstanding: second divide and WAW to r3 both stall.
        issue(5'd3, 2'd3);
        idle(); id_rf_r_addr = 5'd4; id_rf_r_we = 1'b1; id_wb_class = 2'd3; id_issue = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #1 check_eq("second_div_blocked", id_bubble, 32'h1);
        id_rf_r_addr = 5'd3; id_wb_class = 2'd0;
        #1 check_eq("waw_blocked", id_bubble, 32'h1);
        step();
        idle(); div_done = 1'b1; div_addr = 5'd3;
        step();

        // Load to r0 is not tracked.
        issue(5'd0, 2'd1);
        idle(); id_rf_x_used = 1'b1;
        #1 check_eq("r0_no_hazard", id_bubble, 32'h0);
        step();

        // Flush clears everything; later stray completion is ignored.
        issue(5'd5, 2'd1);
        issue(5'd6, 2'd3);
        idle(); flush = 1'b1;
        step();
        idle();
        #1 check_eq("flush_sb_busy", sb_busy, 32'h0);
        check_eq("flush_div_busy", div_busy, 32'h0);
        div_done = 1'b1; div_addr = 5'd6;
        step();

        // Reset mid-countdown.
        issue(5'd7, 2'd2);
        idle(); rst = 1'b1;
        step();
        idle();
        #1 check_eq("rst_sb_busy", sb_busy, 32'h0);
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            id_rf_x_addr = 5'($urandom_range(0, 7));
            id_rf_y_addr = 5'($urandom_range(0, 7));
            id_rf_r_addr = 5'($urandom_range(0, 7));
            id_rf_x_used = 1'($urandom_range(0, 1));
            id_rf_y_used = 1'($urandom_range(0, 1));
            id_rf_r_we   = ($urandom_range(0, 3) != 0);
            id_wb_class  = 2'($urandom_range(0, 3));
            id_issue     = ($urandom_range(0, 3) != 0);
            pipe_stall   = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 40) == 0);
            rst          = ($urandom_range(0, 80) == 0);
            div_done     = m_div_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 30) == 0);
            div_addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 7)) : 5'(div_tgt);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
